jtmx5k_rom_slot: RTL



---
 rtl/jtmx5k_rom_slot_if.sv | 24 ++
 rtl/jtmx5k_rom_slot.sv | 137 +++++++++++++
 2 files changed

// File: rtl/jtmx5k_rom_slot_if.sv
// SDRAM-side bus of one ROM slot in the MX5000 core.
//
// Handshake: the slot raises sdram_req with a stable sdram_addr and keeps both
// unchanged until the arbiter pulses sdram_ack for one cycle; sdram_req drops
// in the cycle after that pulse. data_dst and data_rdy are broadcast to every
// slot. A slot takes the first data_rdy after its own ack as its read word.
interface jtmx5k_rom_slot_if;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_dst;
  logic        data_rdy;
  logic [15:0] data_read;

  modport master (
    output sdram_req, sdram_addr,
    input  sdram_ack, data_dst, data_rdy, data_read
  );

  modport slave (
    input  sdram_req, sdram_addr,
    output sdram_ack, data_dst, data_rdy, data_read
  );
endinterface

// File: rtl/jtmx5k_rom_slot.sv
// One SDRAM read slot for a ROM client. Adds the slot offset to the client
// address, runs the req/ack/data_rdy handshake and keeps a two-entry 16-bit
// word cache. This lets sequential byte reads and ping-pong reads between two
// words return data without a new SDRAM transaction.
// DW must be 8 or 16.
module jtmx5k_rom_slot #(
  parameter int          AW     = 18,
  parameter int          DW     = 8,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    downloading,
  input  logic [AW-1:0]           addr,
  input  logic                    cs,
  output logic                    ok,
  output logic [DW-1:0]           dout,
  jtmx5k_rom_slot_if.master       sdram,
  // {data phase seen, fsm state}
  output logic [2:0]              dbg
);

  // Width of the word address: byte clients drop the byte-select bit.
  localparam int WAW = (DW == 8) ? AW - 1 : AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [WAW-1:0]   waddr;
  logic [WAW-1:0]   fetch_tag;
  logic [21:0]      req_addr;
  logic             dst_seen;

  logic [1:0]       valid;
  logic [WAW-1:0]   tag  [2];
  logic [15:0]      data [2];
  logic             lru;

  logic             hit0;
  logic             hit1;
  logic             hit;
  logic [15:0]      hit_word;
  logic             fill;

  generate
    if (DW == 8) begin : g_byte
      assign waddr = addr[AW-1:1];
      // addr[0] picks the high byte of the cached word
      assign dout  = hit ? (addr[0] ? hit_word[15:8] : hit_word[7:0]) : '0;
    end else begin : g_word
      assign waddr = addr;
      assign dout  = hit ? hit_word : '0;
    end
  endgenerate

  // Carry beyond bit 21 is dropped, so the sum wraps inside SDRAM space.
  assign req_addr = OFFSET + 22'(waddr);

  // Cache lookup is purely combinational so a hit has zero latency.
  assign hit0     = valid[0] && (tag[0] == waddr);
  assign hit1     = valid[1] && (tag[1] == waddr);
  assign hit      = cs && !downloading && (hit0 || hit1);
  assign hit_word = hit0 ? data[0] : data[1];
  assign ok       = hit;

  // A same-cycle ack+data_rdy in REQ counts as ack followed by the fill.
  assign fill = !downloading &&
                (((state == REQ) && sdram.sdram_ack && sdram.data_rdy) ||
                 ((state == WAIT) && sdram.data_rdy));

  assign dbg = {dst_seen, state};

  // Request FSM, cache fill and LRU bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      sdram.sdram_req  <= 1'b0;
      sdram.sdram_addr <= OFFSET;
      fetch_tag        <= '0;
      dst_seen         <= 1'b0;
      valid            <= '0;
      lru              <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else if (downloading) begin
      // The ROM content is changing: drop the cache and any fetch in flight.
      state           <= IDLE;
      sdram.sdram_req <= 1'b0;
      dst_seen        <= 1'b0;
      valid           <= '0;
    end else begin
      // A hit makes the other entry the eviction candidate.
      if (hit) lru <= hit0;

      case (state)
        IDLE: begin
          if (cs && !(hit0 || hit1)) begin
            fetch_tag        <= waddr;
            sdram.sdram_addr <= req_addr;
            sdram.sdram_req  <= 1'b1;
            state            <= REQ;
          end
        end
        REQ: begin
          // The request stays up even if the client moves on.
          if (sdram.sdram_ack) begin
            sdram.sdram_req <= 1'b0;
            state           <= sdram.data_rdy ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (sdram.data_dst) dst_seen <= 1'b1;
          if (sdram.data_rdy) begin
            dst_seen <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Fill overrides the hit update: the new word is the most recent one.
      if (fill) begin
        data[lru]  <= sdram.data_read;
        tag[lru]   <= fetch_tag;
        valid[lru] <= 1'b1;
        lru        <= ~lru;
      end
    end
  end

endmodule
